grf_wport_arbiter: RTL and testbench

// - Shares the single GRF write port (A3/WD/writeEn) between the W-stage writeback and the

---
 rtl/grf_wport_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_grf_wport_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wport_arbiter
//   Shares the single GRF write port between W-stage writeback and the
//   multi-cycle MDU result path. W stage has priority; MDU results wait in a
//   small FIFO. A per-register pending scoreboard tracks issued MDU ops and
//   raises a decode stall on RAW/WAW hazards. An anti-starvation FSM forces
//   one FIFO write (W held off) after STARVE_MAX lost arbitrations.
//
// Parameters
//   QDEPTH      MDU result FIFO entries (power of two, >= 2)
//   STARVE_MAX  cycles a non-empty FIFO may lose before a forced hold cycle
//
// Ports
//   i_clk, i_reset_n              clock, async active-low reset
//   i_w_en/i_w_addr/i_w_data      W-stage write request
//   i_m_valid/i_m_addr/i_m_data   MDU result, accepted when o_m_ready
//   o_m_ready                     FIFO has room (registered occupancy only)
//   i_m_issue/i_m_issue_addr      MDU op issued from decode
//   i_rs_addr/i_rt_addr/i_d_waddr decode-stage register operands
//   o_stall                       decode hazard on a pending register
//   o_w_hold                      W stage must not write this cycle
//   o_grf_we/o_grf_a3/o_grf_wd    GRF write port
//   o_q_count                     FIFO occupancy
//
// Configuration
//   GRF_ARB_ASSERT_EN  enables simulation-only protocol checks; the
//                      synthesized logic is the same either way.
// -----------------------------------------------------------------------------
module grf_wport_arbiter #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_w_en,
  input  logic [4:0]                i_w_addr,
  input  logic [31:0]               i_w_data,
  input  logic                      i_m_valid,
  input  logic [4:0]                i_m_addr,
  input  logic [31:0]               i_m_data,
  output logic                      o_m_ready,
  input  logic                      i_m_issue,
  input  logic [4:0]                i_m_issue_addr,
  input  logic [4:0]                i_rs_addr,
  input  logic [4:0]                i_rt_addr,
  input  logic [4:0]                i_d_waddr,
  output logic                      o_stall,
  output logic                      o_w_hold,
  output logic                      o_grf_we,
  output logic [4:0]                o_grf_a3,
  output logic [31:0]               o_grf_wd,
  output logic [$clog2(QDEPTH):0]   o_q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_NORMAL = 1'b0, S_HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  // FIFO storage carries no reset: pointers and count define validity.
  ent_t          fifo_q [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [31:0]   pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  state_e        state_q, state_d;

  logic full, empty, hold;
  logic w_req, pop, push, m_xfer;
  ent_t head;

  assign full  = (cnt_q == CW'(QDEPTH));
  assign empty = (cnt_q == '0);
  assign hold  = (state_q == S_HOLD);
  assign head  = fifo_q[rptr_q];

  // Grant logic is gated by the reset input so the port is quiet while
  // reset is asserted, not only after the flops clear.
  assign o_m_ready = i_reset_n & ~full;
  assign w_req     = i_reset_n & i_w_en & (i_w_addr != 5'd0) & ~hold;
  assign pop       = i_reset_n & ~w_req & ~empty;
  assign m_xfer    = i_m_valid & o_m_ready;
  // Results to $0 complete the handshake but never occupy a slot.
  assign push      = m_xfer & (i_m_addr != 5'd0);

  always_comb begin
    o_grf_we = 1'b0;
    o_grf_a3 = 5'd0;
    o_grf_wd = 32'd0;
    if (w_req) begin
      o_grf_we = 1'b1;
      o_grf_a3 = i_w_addr;
      o_grf_wd = i_w_data;
    end else if (pop) begin
      o_grf_we = 1'b1;
      o_grf_a3 = head.addr;
      o_grf_wd = head.data;
    end
  end

  assign o_w_hold  = hold;
  assign o_q_count = cnt_q;

  // Stall looks only at registered pending bits, so it drops the cycle after
  // the GRF write of the result.
  assign o_stall = pend_q[i_rs_addr] | pend_q[i_rt_addr] | pend_q[i_d_waddr] |
                   (i_m_issue & pend_q[i_m_issue_addr]);

  // FIFO pointers / occupancy
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pending scoreboard: clear applied first so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.addr] = 1'b0;
    if (i_m_issue && (i_m_issue_addr != 5'd0)) pend_d[i_m_issue_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Anti-starvation FSM
  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    case (state_q)
      S_NORMAL: begin
        if (!empty && w_req) begin
          starve_d = starve_q + 1'b1;
          if (starve_d == SW'(STARVE_MAX)) begin
            state_d  = S_HOLD;
            starve_d = '0;
          end
        end
      end
      S_HOLD: begin
        state_d  = S_NORMAL;
        starve_d = '0;
      end
      default: state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      starve_q <= '0;
      state_q  <= S_NORMAL;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wptr_q] <= '{addr: i_m_addr, data: i_m_data};
  end

`ifdef GRF_ARB_ASSERT_EN
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (i_w_en && o_w_hold) begin
        $display("grf_wport_arbiter: W write during hold");
        $finish;
      end
      if (i_m_valid && full) begin
        $display("grf_wport_arbiter: MDU push while full");
        $finish;
      end
      if (i_m_issue && (i_m_issue_addr != 5'd0) && pend_q[i_m_issue_addr]) begin
        $display("grf_wport_arbiter: issue to pending register %0d", i_m_issue_addr);
        $finish;
      end
      if (pop && !pend_q[head.addr]) begin
        $display("grf_wport_arbiter: pop of non-pending register %0d", head.addr);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;
  localparam int QD = 2;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        w_en = 0, m_valid = 0, m_issue = 0;
  logic [4:0]  w_addr = 0, m_addr = 0, issue_addr = 0, rs = 0, rt = 0, dw = 0;
  logic [31:0] w_data = 0, m_data = 0;
  logic        m_ready, stall, w_hold, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [1:0]  q_count;

  grf_wport_arbiter #(.QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_w_en(w_en), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_m_valid(m_valid), .i_m_addr(m_addr), .i_m_data(m_data), .o_m_ready(m_ready),
    .i_m_issue(m_issue), .i_m_issue_addr(issue_addr),
    .i_rs_addr(rs), .i_rt_addr(rt), .i_d_waddr(dw),
    .o_stall(stall), .o_w_hold(w_hold),
    .o_grf_we(grf_we), .o_grf_a3(grf_a3), .o_grf_wd(grf_wd), .o_q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] a3; logic [31:0] wd;
    logic stall, ready, hold; logic [1:0] cnt;
  } exp_t;
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  // Reference model state
  ent_t mq[$];
  bit   pend[32];
  int   starve;
  bit   mhold;
  bit   acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grf_we", {31'd0, grf_we}, {31'd0, e.we});
      if (e.we) begin
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, e.a3});
        chk("grf_wd", grf_wd, e.wd);
      end
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
      chk("m_ready", {31'd0, m_ready}, {31'd0, e.ready});
      chk("w_hold", {31'd0, w_hold}, {31'd0, e.hold});
      chk("q_count", {30'd0, q_count}, {30'd0, e.cnt});
    end
  end

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 0;
    starve = 0;
    mhold  = 0;
  endtask

  // Drive one cycle, predict its outputs, then advance the model.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wdat,
                     input bit mv, input logic [4:0] ma, input logic [31:0] mdat,
                     input bit iss, input logic [4:0] ia,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                     output bit accepted);
    exp_t e;
    ent_t h;
    bit wreq, popd, empty0;
    @(posedge clk); #1;
    w_en = we; w_addr = wa; w_data = wdat;
    m_valid = mv; m_addr = ma; m_data = mdat;
    m_issue = iss; issue_addr = ia; rs = r1; rt = r2; dw = d;

    e.ready = (mq.size() < QD);
    e.cnt   = 2'(mq.size());
    e.hold  = mhold;
    e.stall = pend[r1] | pend[r2] | pend[d] | (iss & pend[ia]);
    wreq    = we && (wa != 0) && !mhold;
    empty0  = (mq.size() == 0);
    popd    = 0;
    h       = '{a: 5'd0, d: 32'd0};
    if (wreq) begin
      e.we = 1; e.a3 = wa; e.wd = wdat;
    end else if (!empty0) begin
      h = mq.pop_front();
      popd = 1;
      e.we = 1; e.a3 = h.a; e.wd = h.d;
    end else begin
      e.we = 0; e.a3 = 0; e.wd = 0;
    end
    exp_q.push_back(e);

    accepted = mv && e.ready;
    if (popd) pend[h.a] = 0;
    if (iss && ia != 0) pend[ia] = 1;
    if (accepted && ma != 0) mq.push_back('{a: ma, d: mdat});
    if (mhold) begin
      mhold = 0; starve = 0;
    end else if (!empty0 && wreq) begin
      starve++;
      if (starve == SM) begin mhold = 1; starve = 0; end
    end else begin
      starve = 0;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0;
    m_valid = 1; m_addr = 5'd6; m_data = 32'hDEAD;
    w_en = 1; w_addr = 5'd3; w_data = 32'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("rst_grf_a3", {27'd0, grf_a3}, 32'd0);
    chk("rst_grf_wd", grf_wd, 32'd0);
    chk("rst_q_count", {30'd0, q_count}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_w_hold", {31'd0, w_hold}, 32'd0);
    @(posedge clk); #1;
    w_en = 0; w_addr = 0; w_data = 0; m_valid = 0; m_addr = 0; m_data = 0;
    m_issue = 0; issue_addr = 0; rs = 0; rt = 0; dw = 0;
    rst_n = 1;
    model_reset();
    #1;
    chk("rel_m_ready", {31'd0, m_ready}, 32'd1);
  endtask

  task automatic rand_cycles(input int n);
    bit a, we, mv, iss;
    for (int i = 0; i < n; i++) begin
      we  = ($urandom_range(0, 2) != 0) && !mhold;
      mv  = $urandom_range(0, 1);
      iss = ($urandom_range(0, 3) == 0);
      cyc(we, 5'($urandom_range(0, 7)), $urandom,
          mv, 5'($urandom_range(0, 7)), $urandom,
          iss, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a);
    end
  endtask

  initial begin
    logic [4:0]  fa [3];
    logic [31:0] fd [3];
    int tries;
    model_reset();
    #2;
    do_reset();

    // Idle MDU path: issue $5, push result, stall on rs=5 until after write
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0, 0, acc);
    cyc(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 5'd5, 0, 0, acc);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0, 0, acc);

    // Conflict: W hammers $3, $7 waits, then forced hold cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0, acc);
    cyc(1, 5'd3, 32'h300, 1, 5'd7, 32'hAA, 0, 0, 0, 5'd7, 0, acc);
    for (int i = 0; i < 7; i++) cyc(1, 5'd3, 32'h301 + i, 0, 0, 0, 0, 0, 0, 5'd7, 0, acc);

    // Full FIFO with W busy: third result waits for room
    fa[0] = 5'd10; fa[1] = 5'd11; fa[2] = 5'd12;
    fd[0] = 32'hA10; fd[1] = 32'hA11; fd[2] = 32'hA12;
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 1, fa[k], 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) begin
      tries = 0;
      acc = 0;
      while (!acc && tries < 20) begin
        cyc(!mhold, 5'd4, 32'h400 + tries, 1, fa[k], fd[k], 0, 0, fa[0], fa[2], 0, acc);
        tries++;
      end
      if (!acc) begin
        n_chk++; n_fail++;
        $display("FAIL full_accept: item %0d not accepted within %0d cycles", k, tries);
      end
    end
    idle(5);

    // $0 cases: W to $0 frees the port; MDU result to $0 is dropped
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd13, 0, 0, 0, acc);
    cyc(1, 5'd3, 32'h33, 1, 5'd13, 32'h55, 0, 0, 0, 0, 0, acc);
    cyc(1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    cyc(0, 0, 0, 1, 5'd0, 32'h77, 0, 0, 0, 0, 0, acc);
    idle(2);

    // Same-cycle pop and re-issue of $9: set wins
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, acc);
    cyc(1, 5'd2, 32'h22, 1, 5'd9, 32'h99, 0, 0, 0, 5'd9, 0, acc);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9, 0, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, acc);
    cyc(0, 0, 0, 1, 5'd9, 32'h999, 0, 0, 0, 5'd9, 0, acc);
    idle(3);

    rand_cycles(250);
    do_reset();
    rand_cycles(250);
    idle(4);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
